// File: rtl/flash_read_scheduler_if.sv
// Bus bundle for the flash read scheduler: CPU read port, DMA run port and the
// Avalon-MM read port toward the flash IP. The slave modport is the
// scheduler's view; the master modport is the surrounding system's view.
interface flash_read_scheduler_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
);
    logic                  cpu_req;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_ack;
    logic [31:0]           cpu_rdata;
    logic                  cpu_rvalid;

    logic                  dma_start;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [LEN_WIDTH-1:0]  dma_len;
    logic                  dma_stop;
    logic                  dma_busy;
    logic [31:0]           dma_rdata;
    logic                  dma_rvalid;
    logic                  dma_done;

    logic [ADDR_WIDTH-1:0] flash_addr;
    logic                  flash_read;
    logic [1:0]            flash_burstcount;
    logic                  flash_waitrequest;
    logic [31:0]           flash_readdata;
    logic                  flash_readdatavalid;

    modport slave (
        input  cpu_req, cpu_addr, dma_start, dma_addr, dma_len, dma_stop,
               flash_waitrequest, flash_readdata, flash_readdatavalid,
        output cpu_ack, cpu_rdata, cpu_rvalid, dma_busy, dma_rdata, dma_rvalid,
               dma_done, flash_addr, flash_read, flash_burstcount
    );

    modport master (
        output cpu_req, cpu_addr, dma_start, dma_addr, dma_len, dma_stop,
               flash_waitrequest, flash_readdata, flash_readdatavalid,
        input  cpu_ack, cpu_rdata, cpu_rvalid, dma_busy, dma_rdata, dma_rvalid,
               dma_done, flash_addr, flash_read, flash_burstcount
    );
endinterface

// File: rtl/flash_read_scheduler.sv
// Shares the configuration flash read port between a CPU (single-word reads)
// and a DMA (word runs split into bursts of 2, last burst 1 when odd).
// Round-robin arbitration per transaction, one transaction outstanding,
// read data routed back to the owner of the transaction in flight.
module flash_read_scheduler #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    flash_read_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;

    logic                  owner_dma_r;     // owner of the transaction in flight
    logic                  prio_dma_r;      // DMA wins the next tie
    logic [1:0]            beats_left_r;
    logic [ADDR_WIDTH-1:0] flash_addr_r;
    logic [1:0]            flash_bc_r;

    logic                  dma_busy_r;
    logic                  dma_done_r;
    logic                  dma_stop_pend_r;
    logic [ADDR_WIDTH-1:0] dma_addr_r;      // next word address of the run
    logic [LEN_WIDTH-1:0]  dma_rem_r;       // words not yet issued

    logic                  cpu_elig_s;
    logic                  dma_elig_s;
    logic                  stop_any_s;
    logic                  dma_rem_zero_s;
    logic [1:0]            dma_bc_s;
    logic                  dma_in_flight_s;
    logic                  end_run_s;
    logic                  grant_s;
    logic                  grant_dma_s;
    logic                  accept_s;
    logic                  beat_s;
    logic                  last_beat_s;
    logic                  cpu_rvalid_s;
    logic                  dma_rvalid_s;
    logic [31:0]           cpu_rdata_s;
    logic [31:0]           dma_rdata_s;

    // A stop counts as soon as it is seen so it can preempt a grant in IDLE.
    assign stop_any_s      = dma_stop_pend_r | bus.dma_stop;
    assign dma_rem_zero_s  = (dma_rem_r == {LEN_WIDTH{1'b0}});
    assign cpu_elig_s      = bus.cpu_req;
    assign dma_elig_s      = dma_busy_r & ~dma_rem_zero_s & ~stop_any_s;
    assign dma_bc_s        = (|dma_rem_r[LEN_WIDTH-1:1]) ? 2'd2 : 2'd1;
    assign dma_in_flight_s = (state_r != ST_IDLE) & owner_dma_r;

    // Run ends after its final beat, after the beat closing a stopped burst,
    // or right away when a stop lands while no DMA burst is in flight.
    assign end_run_s = dma_busy_r &
                       ((last_beat_s & owner_dma_r & (dma_rem_zero_s | stop_any_s)) |
                        (~dma_in_flight_s & stop_any_s));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic, arbitration and transaction phase strobes
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        grant_dma_s = 1'b0;
        accept_s    = 1'b0;
        beat_s      = 1'b0;
        last_beat_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_elig_s || dma_elig_s) begin
                    grant_s     = 1'b1;
                    grant_dma_s = dma_elig_s & (~cpu_elig_s | prio_dma_r);
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!bus.flash_waitrequest) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DATA: begin
                if (bus.flash_readdatavalid) begin
                    beat_s = 1'b1;
                    if (beats_left_r == 2'd1) begin
                        last_beat_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Latch owner, address and burst size at grant; count beats per burst
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_dma_r  <= 1'b0;
            prio_dma_r   <= 1'b0;
            flash_addr_r <= {ADDR_WIDTH{1'b0}};
            flash_bc_r   <= 2'd1;
            beats_left_r <= 2'd0;
        end else begin
            if (grant_s) begin
                owner_dma_r  <= grant_dma_s;
                prio_dma_r   <= ~grant_dma_s;
                flash_addr_r <= grant_dma_s ? dma_addr_r : bus.cpu_addr;
                flash_bc_r   <= grant_dma_s ? dma_bc_s : 2'd1;
            end
            if (accept_s) begin
                beats_left_r <= flash_bc_r;
            end else if (beat_s) begin
                beats_left_r <= beats_left_r - 2'd1;
            end
        end
    end

    // DMA run bookkeeping: start, pending stop, address/remaining, completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_busy_r      <= 1'b0;
            dma_done_r      <= 1'b0;
            dma_stop_pend_r <= 1'b0;
            dma_addr_r      <= {ADDR_WIDTH{1'b0}};
            dma_rem_r       <= {LEN_WIDTH{1'b0}};
        end else begin
            dma_done_r <= 1'b0;
            if (!dma_busy_r && bus.dma_start) begin
                dma_stop_pend_r <= 1'b0;
                dma_addr_r      <= bus.dma_addr;
                dma_rem_r       <= bus.dma_len;
                if (bus.dma_len == {LEN_WIDTH{1'b0}}) begin
                    dma_done_r <= 1'b1;
                end else begin
                    dma_busy_r <= 1'b1;
                end
            end else if (end_run_s) begin
                dma_busy_r      <= 1'b0;
                dma_done_r      <= 1'b1;
                dma_stop_pend_r <= 1'b0;
            end else begin
                if (dma_busy_r && bus.dma_stop) begin
                    dma_stop_pend_r <= 1'b1;
                end
                if (accept_s && owner_dma_r) begin
                    dma_addr_r <= dma_addr_r + {{(ADDR_WIDTH-2){1'b0}}, flash_bc_r};
                    dma_rem_r  <= dma_rem_r - {{(LEN_WIDTH-2){1'b0}}, flash_bc_r};
                end
            end
        end
    end

    // Route each returned beat to its owner; data reads zero when not valid
    always_comb begin
        cpu_rvalid_s = beat_s & ~owner_dma_r;
        dma_rvalid_s = beat_s & owner_dma_r;
        if (cpu_rvalid_s) begin
            cpu_rdata_s = bus.flash_readdata;
        end else begin
            cpu_rdata_s = 32'd0;
        end
        if (dma_rvalid_s) begin
            dma_rdata_s = bus.flash_readdata;
        end else begin
            dma_rdata_s = 32'd0;
        end
    end

    assign bus.flash_read       = (state_r == ST_ISSUE);
    assign bus.flash_addr       = flash_addr_r;
    assign bus.flash_burstcount = flash_bc_r;
    assign bus.cpu_ack          = accept_s & ~owner_dma_r;
    assign bus.cpu_rvalid       = cpu_rvalid_s;
    assign bus.cpu_rdata        = cpu_rdata_s;
    assign bus.dma_rvalid       = dma_rvalid_s;
    assign bus.dma_rdata        = dma_rdata_s;
    assign bus.dma_busy         = dma_busy_r;
    assign bus.dma_done         = dma_done_r;

endmodule
